stream_mux_arb: RTL

- Parametrised N-channel, W-bit stream multiplexer with a valid/ready handshake on every input and on the output.
- Successor to the 2:1 combinational mux. Adds run-time-free selection modes, a registered output stage, and backpressure.
- Sits between several producers and one consumer: picks one input per transfer and forwards it with 1-cycle latency.

---
 rtl/stream_mux_pkg.sv | 19 +
 rtl/stream_mux_arb_rr_arbiter.sv | 68 ++++++
 rtl/stream_mux_arb.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/stream_mux_pkg.sv
// Shared definitions for the stream multiplexer/arbiter: selection policy codes,
// output-stage state encoding and the channel-index width helper.
package stream_mux_pkg;

    localparam int MODE_SEL  = 0;
    localparam int MODE_RR   = 1;
    localparam int MODE_PRIO = 2;

    // Output stage state; the encoding doubles as out_valid.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    function automatic int calc_selw(input int n_ch);
        return (n_ch < 2) ? 1 : $clog2(n_ch);
    endfunction

endpackage

// File: rtl/stream_mux_arb_rr_arbiter.sv
// Round-robin request search with its rotating start pointer; the pointer moves
// to the channel after the winner only when a transfer actually takes place.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter  int N_CH = 4,
    localparam int SELW = calc_selw(N_CH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] req,
    input  logic            advance,
    output logic [SELW-1:0] grant_idx,
    output logic            grant_valid
);

    logic [SELW-1:0] ptr_r;
    logic [SELW-1:0] hi_idx_s;
    logic [SELW-1:0] lo_idx_s;
    logic            hi_found_s;
    logic            lo_found_s;

    // Search ptr..N_CH-1 first; if nothing there, the lowest requester is the wrapped winner
    always_comb begin
        hi_found_s  = 1'b0;
        lo_found_s  = 1'b0;
        hi_idx_s    = {SELW{1'b0}};
        lo_idx_s    = {SELW{1'b0}};
        grant_idx   = {SELW{1'b0}};
        grant_valid = 1'b0;
        for (int j = 0; j < N_CH; j++) begin
            if (req[j] && !hi_found_s && (SELW'(j) >= ptr_r)) begin
                hi_found_s = 1'b1;
                hi_idx_s   = SELW'(j);
            end else begin
                hi_found_s = hi_found_s;
            end
            if (req[j] && !lo_found_s) begin
                lo_found_s = 1'b1;
                lo_idx_s   = SELW'(j);
            end else begin
                lo_found_s = lo_found_s;
            end
        end
        if (hi_found_s) begin
            grant_idx = hi_idx_s;
        end else begin
            grant_idx = lo_idx_s;
        end
        grant_valid = hi_found_s | lo_found_s;
    end

    // Pointer register; explicit wrap keeps it below N_CH for non-power-of-two counts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r <= {SELW{1'b0}};
        end else if (advance) begin
            if (grant_idx == SELW'(N_CH - 1)) begin
                ptr_r <= {SELW{1'b0}};
            end else begin
                ptr_r <= grant_idx + SELW'(1);
            end
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/stream_mux_arb.sv
// N-channel valid/ready stream multiplexer with a one-word registered output stage.
// The selection policy is fixed at elaboration by MODE (external sel, round-robin, priority).
module stream_mux_arb
    import stream_mux_pkg::*;
#(
    parameter  int N_CH = 4,
    parameter  int DW   = 8,
    parameter  int MODE = 1,
    localparam int SELW = calc_selw(N_CH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_CH*DW-1:0] in_data,
    input  logic [N_CH-1:0]    in_valid,
    output logic [N_CH-1:0]    in_ready,
    input  logic [SELW-1:0]    sel,
    output logic [DW-1:0]      out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SELW-1:0]    out_ch
);

    out_state_e      state_r;
    out_state_e      state_n;
    logic            load_en_s;
    logic            xfer_s;
    logic [SELW-1:0] grant_idx_s;
    logic            grant_valid_s;
    logic [DW-1:0]   mux_data_s;
    logic [DW-1:0]   data_r;
    logic [SELW-1:0] ch_r;

    generate
        if (MODE == MODE_RR) begin : g_rr
            logic sel_unused_s;
            assign sel_unused_s = ^sel;

            rr_arbiter #(.N_CH(N_CH)) u_rr (
                .clk         (clk),
                .rst         (rst),
                .req         (in_valid),
                .advance     (xfer_s),
                .grant_idx   (grant_idx_s),
                .grant_valid (grant_valid_s)
            );
        end else if (MODE == MODE_SEL) begin : g_sel
            // Compare against each legal index so an out-of-range sel simply matches nothing
            always_comb begin
                grant_idx_s   = {SELW{1'b0}};
                grant_valid_s = 1'b0;
                for (int j = 0; j < N_CH; j++) begin
                    if ((sel == SELW'(j)) && in_valid[j]) begin
                        grant_idx_s   = SELW'(j);
                        grant_valid_s = 1'b1;
                    end else begin
                        grant_valid_s = grant_valid_s;
                    end
                end
            end
        end else begin : g_prio
            logic sel_unused_s;
            assign sel_unused_s = ^sel;

            // Lowest-index valid channel wins
            always_comb begin
                grant_idx_s   = {SELW{1'b0}};
                grant_valid_s = 1'b0;
                for (int j = 0; j < N_CH; j++) begin
                    if (in_valid[j] && !grant_valid_s) begin
                        grant_idx_s   = SELW'(j);
                        grant_valid_s = 1'b1;
                    end else begin
                        grant_valid_s = grant_valid_s;
                    end
                end
            end
        end
    endgenerate

    assign xfer_s = load_en_s & grant_valid_s;

    // Ready fan-out and data select for the granted channel
    always_comb begin
        in_ready   = {N_CH{1'b0}};
        mux_data_s = {DW{1'b0}};
        for (int j = 0; j < N_CH; j++) begin
            if (grant_idx_s == SELW'(j)) begin
                in_ready[j] = xfer_s;
                mux_data_s  = in_data[j*DW +: DW];
            end else begin
                in_ready[j] = 1'b0;
            end
        end
    end

    // Output-stage next state; FULL may drain and refill in the same cycle
    always_comb begin
        state_n   = state_r;
        load_en_s = 1'b1;
        case (state_r)
            ST_EMPTY: begin
                load_en_s = 1'b1;
                if (grant_valid_s) begin
                    state_n = ST_FULL;
                end else begin
                    state_n = ST_EMPTY;
                end
            end
            ST_FULL: begin
                load_en_s = out_ready;
                if (out_ready && !grant_valid_s) begin
                    state_n = ST_EMPTY;
                end else begin
                    state_n = ST_FULL;
                end
            end
            default: begin
                load_en_s = 1'b0;
                state_n   = ST_EMPTY;
            end
        endcase
    end

    // Output-stage state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_n;
        end
    end

    // Payload registers; a drain alone leaves the last word and channel in place
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_r <= {DW{1'b0}};
            ch_r   <= {SELW{1'b0}};
        end else if (xfer_s) begin
            data_r <= mux_data_s;
            ch_r   <= grant_idx_s;
        end else begin
            data_r <= data_r;
            ch_r   <= ch_r;
        end
    end

    assign out_valid = (state_r == ST_FULL);
    assign out_data  = data_r;
    assign out_ch    = ch_r;

endmodule
